// File: rtl/simplebus_burst_mem.sv
`default_nettype none
// ============================================================================
// simplebus_burst_mem : SimpleBus slave memory, wrapping bursts, fixed latency
// Rev 1.0
// ============================================================================
module simplebus_burst_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int USER_W      = 16,
  parameter int BEATS       = 8,
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_LAT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_bits_addr,
  input  logic [2:0]          req_bits_size,
  input  logic [3:0]          req_bits_cmd,
  input  logic [DATA_W/8-1:0] req_bits_wmask,
  input  logic [DATA_W-1:0]   req_bits_wdata,
  input  logic [USER_W-1:0]   req_bits_user,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [3:0]          resp_bits_cmd,
  output logic [DATA_W-1:0]   resp_bits_rdata,
  output logic [USER_W-1:0]   resp_bits_user
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(BEATS);
  localparam int WA_W  = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam int NB    = DATA_W / 8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [3:0] C_READ   = 4'b0000;
  localparam logic [3:0] C_WRITE  = 4'b0001;
  localparam logic [3:0] C_RBURST = 4'b0010;
  localparam logic [3:0] C_WBURST = 4'b0011;
  localparam logic [3:0] C_WLAST  = 4'b0111;
  localparam logic [3:0] C_RLAST  = 4'b0110;
  localparam logic [3:0] C_WRESP  = 4'b0101;

  localparam logic [WA_W-1:0]  C_LINE_MASK = WA_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] C_BEAT_MAX  = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] C_CNT_END   = CNT_W'(RESP_LAT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cmd;
  logic [USER_W-1:0] r_user;
  logic [WA_W-1:0]   r_widx;
  logic [IDX_W-1:0]  r_beat;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [WA_W-1:0]   w_req_widx;
  logic              w_accept;
  logic              w_resp_hs;
  logic [IDX_W-1:0]  w_beat_sel;
  logic [IDX_W-1:0]  w_low;
  logic [WA_W-1:0]   w_cur_idx;
  logic [WA_W-1:0]   w_wr_idx;
  logic              w_wr_en;
  logic              w_is_wr;
  logic              w_more;
  logic [3:0]        w_nxt_cmd;
  logic [DATA_W-1:0] w_nxt_data;
  logic              w_unused;

  assign w_unused   = ^{req_bits_size, req_bits_addr};
  assign w_req_widx = req_bits_addr[OFF_W +: WA_W];

  assign req_ready  = !rst && (r_state == S_IDLE || r_state == S_WR_BURST);
  assign resp_valid = (r_state == S_RESP);
  assign w_accept   = req_valid && req_ready;
  assign w_resp_hs  = resp_valid && resp_ready;

  // In RESP the index looks one beat ahead so the next word is ready at the handshake
  assign w_beat_sel = (r_state == S_RESP) ? r_beat + IDX_W'(1) : r_beat;
  assign w_low      = r_widx[IDX_W-1:0] + w_beat_sel;
  assign w_cur_idx  = (r_widx & ~C_LINE_MASK) | WA_W'(w_low);

  assign w_wr_idx = (r_state == S_IDLE) ? w_req_widx : w_cur_idx;
  assign w_wr_en  = w_accept && ((r_state == S_WR_BURST) ||
                                 req_bits_cmd == C_WRITE || req_bits_cmd == C_WBURST);

  assign w_is_wr = (r_cmd == C_WRITE) || (r_cmd == C_WBURST);
  assign w_more  = (r_cmd == C_RBURST) && (r_beat != C_BEAT_MAX);

  always_comb begin
    w_nxt_cmd  = C_RLAST;
    w_nxt_data = '0;
    if (w_is_wr) begin
      w_nxt_cmd = C_WRESP;
    end else if (r_cmd == C_RBURST) begin
      w_nxt_cmd  = (w_beat_sel == C_BEAT_MAX) ? C_RLAST : C_READ;
      w_nxt_data = mem[w_cur_idx];
    end else if (r_cmd == C_READ) begin
      w_nxt_data = mem[w_cur_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (req_bits_wmask[b]) mem[w_wr_idx][b*8 +: 8] <= req_bits_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cmd           <= '0;
      r_user          <= '0;
      r_widx          <= '0;
      r_beat          <= '0;
      r_cnt           <= '0;
      resp_bits_cmd   <= '0;
      resp_bits_rdata <= '0;
      resp_bits_user  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd  <= req_bits_cmd;
            r_user <= req_bits_user;
            r_widx <= w_req_widx;
            r_cnt  <= '0;
            if (req_bits_cmd == C_WBURST) begin
              r_beat  <= IDX_W'(1);
              r_state <= S_WR_BURST;
            end else begin
              r_beat  <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WR_BURST: begin
          if (w_accept) begin
            r_beat <= r_beat + IDX_W'(1);
            if (req_bits_cmd == C_WLAST) begin
              r_user  <= req_bits_user;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == C_CNT_END) begin
            r_beat          <= '0;
            resp_bits_cmd   <= w_nxt_cmd;
            resp_bits_rdata <= w_nxt_data;
            resp_bits_user  <= r_user;
            r_state         <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (w_resp_hs) begin
            if (w_more) begin
              r_beat          <= w_beat_sel;
              resp_bits_cmd   <= w_nxt_cmd;
              resp_bits_rdata <= w_nxt_data;
            end else begin
              resp_bits_cmd   <= '0;
              resp_bits_rdata <= '0;
              resp_bits_user  <= '0;
              r_state         <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
